instr_decode: RTL and testbench

- Upstream stage of the register-file/ALU datapath.
- Accepts a 16-bit instruction-word stream over a valid/ready handshake and assembles 3-word instructions, or 5-word instructions when a 32-bit constant is attached.
- Issues the fully decoded control bundle to the datapath for exactly one clock per instruction, with register-write enables gated to that cycle.

---
 rtl/instr_decode.sv | 150 +++++++++++++++
 tb/tb_instr_decode.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode.sv
`default_nettype none
// ============================================================================
// Module   : instr_decode
// Function : Assembles 3/5-word instructions from a 16-bit stream; one-cycle issue.
// Revision : 1.0
// ============================================================================
module instr_decode #(
    parameter int WORD_W  = 16,
    parameter int CONST_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               stall,
    output logic [2:0]         op,
    output logic               form,
    output logic [1:0]         vec,
    output logic [3:0]         A,
    output logic [3:0]         B,
    output logic [3:0]         C,
    output logic [3:0]         D,
    output logic [3:0]         Y1,
    output logic [3:0]         Y2,
    output logic [3:0]         zero_reg,
    output logic               const_a,
    output logic [CONST_W-1:0] constant,
    output logic [1:0]         write,
    output logic               issue,
    output logic               err
);

    localparam logic [2:0] S_W0    = 3'd0;
    localparam logic [2:0] S_W1    = 3'd1;
    localparam logic [2:0] S_W2    = 3'd2;
    localparam logic [2:0] S_KHI   = 3'd3;
    localparam logic [2:0] S_KLO   = 3'd4;
    localparam logic [2:0] S_ISSUE = 3'd5;

    logic [2:0]         r_state;
    logic               r_bad;
    logic               r_err;
    logic [2:0]         r_op;
    logic               r_form;
    logic [1:0]         r_vec;
    logic               r_const_a;
    logic [1:0]         r_write;
    logic [3:0]         r_zero_reg;
    logic [3:0]         r_a, r_b, r_c, r_d;
    logic [3:0]         r_y1, r_y2;
    logic [CONST_W-1:0] r_const;

    logic               w_xfer;
    logic               w_w2_bad;

    assign in_ready = (r_state != S_ISSUE);
    assign w_xfer   = in_valid & in_ready;
    assign w_w2_bad = |in_data[7:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_W0;
            r_bad      <= 1'b0;
            r_err      <= 1'b0;
            r_op       <= '0;
            r_form     <= 1'b0;
            r_vec      <= '0;
            r_const_a  <= 1'b0;
            r_write    <= '0;
            r_zero_reg <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_y1       <= '0;
            r_y2       <= '0;
            r_const    <= '0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                S_W0: if (w_xfer) begin
                    r_op       <= in_data[15:13];
                    r_form     <= in_data[12];
                    r_vec      <= in_data[11:10];
                    r_const_a  <= in_data[9];
                    r_write    <= in_data[8:7];
                    r_zero_reg <= in_data[6:3];
                    r_bad      <= |in_data[2:0];
                    if (!in_data[9]) r_const <= '0;
                    r_state    <= S_W1;
                end
                S_W1: if (w_xfer) begin
                    r_a     <= in_data[15:12];
                    r_b     <= in_data[11:8];
                    r_c     <= in_data[7:4];
                    r_d     <= in_data[3:0];
                    r_state <= S_W2;
                end
                S_W2: if (w_xfer) begin
                    r_y1 <= in_data[15:12];
                    r_y2 <= in_data[11:8];
                    // A bad 3-word instruction is dropped here; 5-word ones carry the flag on.
                    if (r_const_a) begin
                        r_bad   <= r_bad | w_w2_bad;
                        r_state <= S_KHI;
                    end else if (r_bad | w_w2_bad) begin
                        r_err   <= 1'b1;
                        r_state <= S_W0;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_KHI: if (w_xfer) begin
                    r_const[31:16] <= in_data;
                    r_state        <= S_KLO;
                end
                S_KLO: if (w_xfer) begin
                    r_const[15:0] <= in_data;
                    if (r_bad) begin
                        r_err   <= 1'b1;
                        r_state <= S_W0;
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: if (!stall) r_state <= S_W0;
                default: r_state <= S_W0;
            endcase
        end
    end

    assign issue    = (r_state == S_ISSUE) & ~stall;
    assign write    = issue ? r_write : 2'b00;
    assign err      = r_err;
    assign op       = r_op;
    assign form     = r_form;
    assign vec      = r_vec;
    assign const_a  = r_const_a;
    assign zero_reg = r_zero_reg;
    assign A        = r_a;
    assign B        = r_b;
    assign C        = r_c;
    assign D        = r_d;
    assign Y1       = r_y1;
    assign Y2       = r_y2;
    assign constant = r_const;

endmodule
`default_nettype wire

// File: tb/tb_instr_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_decode
// Function : Directed and randomized checks of instr_decode against a field-level model.
// Revision : 1.0
// ============================================================================
module tb_instr_decode;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        stall;
    logic [2:0]  op;
    logic        form;
    logic [1:0]  vec;
    logic [3:0]  A, B, C, D, Y1, Y2, zero_reg;
    logic        const_a;
    logic [31:0] constant;
    logic [1:0]  write;
    logic        issue;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    logic [15:0] w[5];
    int          bub[5];

    instr_decode #(.WORD_W(16), .CONST_W(32)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .stall(stall), .op(op), .form(form), .vec(vec),
        .A(A), .B(B), .C(C), .D(D), .Y1(Y1), .Y2(Y2), .zero_reg(zero_reg),
        .const_a(const_a), .constant(constant), .write(write),
        .issue(issue), .err(err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] dut_fields();
        return {13'd0, op, form, vec, A, B, C, D, Y1, Y2, zero_reg, const_a, constant};
    endfunction

    // Reference decode straight from the word layout, using plain arithmetic.
    function automatic logic [79:0] model_fields();
        int x0 = int'(w[0]);
        int x1 = int'(w[1]);
        int x2 = int'(w[2]);
        logic [2:0]  e_op  = 3'((x0 / 8192) % 8);
        logic        e_fm  = 1'((x0 / 4096) % 2);
        logic [1:0]  e_vec = 2'((x0 / 1024) % 4);
        logic        e_ca  = 1'((x0 / 512) % 2);
        logic [3:0]  e_zr  = 4'((x0 / 8) % 16);
        logic [3:0]  e_a   = 4'(x1 / 4096);
        logic [3:0]  e_b   = 4'((x1 / 256) % 16);
        logic [3:0]  e_c   = 4'((x1 / 16) % 16);
        logic [3:0]  e_d   = 4'(x1 % 16);
        logic [3:0]  e_y1  = 4'(x2 / 4096);
        logic [3:0]  e_y2  = 4'((x2 / 256) % 16);
        logic [31:0] e_k   = e_ca ? (32'(w[3]) * 32'd65536 + 32'(w[4])) : 32'd0;
        return {13'd0, e_op, e_fm, e_vec, e_a, e_b, e_c, e_d, e_y1, e_y2, e_zr, e_ca, e_k};
    endfunction

    function automatic logic [1:0] model_write();
        return 2'((int'(w[0]) / 128) % 4);
    endfunction

    function automatic bit model_bad();
        return ((int'(w[0]) % 8) != 0) || ((int'(w[2]) % 256) != 0);
    endfunction

    function automatic int model_len();
        return ((int'(w[0]) / 512) % 2 == 1) ? 5 : 3;
    endfunction

    // Streams one instruction from w[]/bub[] and checks the issue (or error) cycle.
    task automatic send(input int nstall);
        int          n   = model_len();
        logic [79:0] ef  = model_fields();
        logic [1:0]  ew  = model_write();
        bit          bad = model_bad();
        for (int i = 0; i < n; i++) begin
            for (int b = 0; b < bub[i]; b++) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                stall    = 1'($urandom % 2);
                @(negedge clk);
                chk("ready_in_bubble", 80'(in_ready), 80'd1);
                chk("quiet_in_bubble", 80'({issue, err, write}), 80'd0);
                cyc();
            end
            in_valid = 1'b1;
            in_data  = w[i];
            stall    = 1'($urandom % 2);
            @(negedge clk);
            chk("ready_for_word", 80'(in_ready), 80'd1);
            chk("quiet_in_fetch", 80'({issue, err, write}), 80'd0);
            cyc();
        end
        in_valid = 1'b0;
        if (bad) begin
            stall = 1'($urandom % 2);
            @(negedge clk);
            chk("err_pulse", 80'({err, issue, write}), 80'b1000);
            chk("ready_after_err", 80'(in_ready), 80'd1);
            chk("fields_at_err", dut_fields(), ef);
            cyc();
            @(negedge clk);
            chk("err_single", 80'({err, issue}), 80'd0);
            cyc();
        end else begin
            for (int s = 0; s < nstall; s++) begin
                stall = 1'b1;
                @(negedge clk);
                chk("stall_quiet", 80'({issue, write, in_ready, err}), 80'd0);
                chk("stall_fields", dut_fields(), ef);
                cyc();
            end
            stall = 1'b0;
            @(negedge clk);
            chk("issue_pulse", 80'({issue, write, in_ready, err}), 80'({1'b1, ew, 1'b0, 1'b0}));
            chk("issue_fields", dut_fields(), ef);
            cyc();
            @(negedge clk);
            chk("after_issue", 80'({issue, write, err, in_ready}), 80'd1);
            cyc();
        end
    endtask

    task automatic set_words(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                             input logic [15:0] d, input logic [15:0] e);
        w[0] = a; w[1] = b; w[2] = c; w[3] = d; w[4] = e;
        for (int i = 0; i < 5; i++) bub[i] = 0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 16'h0000;
        stall    = 1'b0;
        @(negedge clk);
        chk("reset_fields", dut_fields(), 80'd0);
        chk("reset_ctrl", 80'({issue, err, write}), 80'd0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 80'(in_ready), 80'd1);
        cyc();

        // Reset while W1 is pending: the partial instruction must vanish.
        in_valid = 1'b1;
        in_data  = 16'h2A00;
        cyc();
        in_data  = 16'hFFFF;
        #2 rst = 1'b1;
        @(negedge clk);
        chk("midinstr_reset_fields", dut_fields(), 80'd0);
        chk("midinstr_reset_ctrl", 80'({issue, err, write}), 80'd0);
        cyc();
        rst      = 1'b0;
        in_valid = 1'b0;
        set_words(16'h1234, 16'h0000, 16'h7000, 16'hDEAD, 16'hBEEF);
        in_valid = 1'b1;
        in_data  = w[0];
        @(negedge clk);
        chk("ready_post_reset", 80'(in_ready), 80'd1);
        cyc();
        in_valid = 1'b0;
        @(negedge clk);
        chk("w0_after_reset", 80'({op, zero_reg, const_a}), 80'({3'd0, 4'b0110, 1'b1}));
        cyc();
        bub[0] = 0;
        w[0] = w[1]; w[1] = w[2]; w[2] = w[3]; w[3] = w[4];
        // Finish the remaining four words by hand; the malformed W0 must raise err.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("reset_case_err", 80'({err, issue, write}), 80'b1000);
        cyc();
        cyc();

        set_words(16'hB580, 16'h1234, 16'h5600, 16'h0000, 16'h0000);
        send(0);
        set_words(16'h0280, 16'h89AB, 16'h7000, 16'hDEAD, 16'hBEEF);
        send(0);
        set_words(16'hB580, 16'h1234, 16'h5600, 16'h0000, 16'h0000);
        send(3);
        set_words(16'hB580, 16'h1234, 16'h5600, 16'h0000, 16'h0000);
        bub[1] = 2;
        bub[2] = 1;
        send(0);
        set_words(16'hB580, 16'h1234, 16'h5601, 16'h0000, 16'h0000);
        send(0);
        set_words(16'h6D80, 16'hFEDC, 16'hA900, 16'h0000, 16'h0000);
        send(1);

        for (int t = 0; t < 40; t++) begin
            w[0] = 16'($urandom);
            w[1] = 16'($urandom);
            w[2] = 16'($urandom);
            w[3] = 16'($urandom);
            w[4] = 16'($urandom);
            if ($urandom % 5 != 0) begin
                w[0] = w[0] & 16'hFFF8;
                w[2] = w[2] & 16'hFF00;
            end
            for (int i = 0; i < 5; i++) bub[i] = int'($urandom % 3);
            send(int'($urandom % 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
